// File: rtl/ball_launcher_if.sv
// Ball launcher bus: game-side controls in, launcher status out.
interface ball_launcher_if;
    logic [2:0] state;
    logic       fire;
    logic [7:0] hole_hit;
    logic       gate;
    logic       busy;
    logic [3:0] ball_left;
    logic [2:0] last_hole;
    logic       hit_valid;
    logic       lost;
    logic       empty;

    // Game/front-end side drives requests and watches status
    modport master (
        output state, fire, hole_hit,
        input  gate, busy, ball_left, last_hole, hit_valid, lost, empty
    );

    // Launcher side
    modport slave (
        input  state, fire, hole_hit,
        output gate, busy, ball_left, last_hole, hit_valid, lost, empty
    );
endinterface

// File: rtl/ball_launcher.sv
// Ball launcher: one gate pulse per accepted fire, then waits in flight for a
// hole hit or a timeout. Tracks remaining balls and the last hole reached.
module ball_launcher #(
    parameter int unsigned BALLS       = 8,
    parameter int unsigned GATE_CYC    = 5_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic            clk,
    input  logic            rst,
    ball_launcher_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GATE, FLIGHT} fsm_t;

    localparam logic [2:0]  ST_RESET = 3'd0;
    localparam logic [2:0]  ST_START = 3'd2;
    localparam logic [2:0]  ST_GET   = 3'd3;
    localparam logic [31:0] GATE_LAST = 32'(GATE_CYC - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  BALLS_W   = 4'(BALLS);

    fsm_t        fsm_q;
    logic [31:0] cnt_q;
    logic        gate_q;
    logic        busy_q;
    logic [3:0]  ball_left_q;
    logic [2:0]  last_hole_q;
    logic        hit_valid_q;
    logic        lost_q;

    logic        launch_ok;
    logic        any_hit;
    logic [2:0]  hit_idx_d;

    // Lowest set bit wins when several holes report together
    function automatic logic [2:0] low_idx(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Launch qualification and hit decode, all from inputs sampled at the edge
    always_comb begin
        launch_ok = bus.fire && (bus.state == ST_START || bus.state == ST_GET)
                    && (ball_left_q != 4'd0);
        any_hit   = |bus.hole_hit;
        hit_idx_d = low_idx(bus.hole_hit);
    end

    // Launcher FSM with registered outputs; rst and game RESET both abort
    always_ff @(posedge clk) begin
        if (rst || bus.state == ST_RESET) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            gate_q      <= 1'b0;
            busy_q      <= 1'b0;
            ball_left_q <= BALLS_W;
            last_hole_q <= '0;
            hit_valid_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            hit_valid_q <= 1'b0;
            lost_q      <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (launch_ok) begin
                        fsm_q       <= GATE;
                        cnt_q       <= '0;
                        gate_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        ball_left_q <= ball_left_q - 4'd1;
                    end
                end
                GATE: begin
                    if (cnt_q == GATE_LAST) begin
                        fsm_q  <= FLIGHT;
                        cnt_q  <= '0;
                        gate_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                FLIGHT: begin
                    // A hit on the timeout cycle still counts as a hit
                    if (any_hit) begin
                        fsm_q       <= IDLE;
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        last_hole_q <= hit_idx_d;
                        hit_valid_q <= 1'b1;
                    end else if (cnt_q == TMO_LAST) begin
                        fsm_q  <= IDLE;
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                        lost_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    fsm_q  <= IDLE;
                    cnt_q  <= '0;
                    gate_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gate      = gate_q;
    assign bus.busy      = busy_q;
    assign bus.ball_left = ball_left_q;
    assign bus.last_hole = last_hole_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.lost      = lost_q;
    assign bus.empty     = (ball_left_q == 4'd0) && (fsm_q == IDLE);

endmodule
